// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder: FSM encoding,
// error-cause codes and the latched request record.
package dmem_responder_pkg;

  localparam int DMR_WAIT_DEFAULT = 2;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_BUSY = 2'd1,
    DMR_DONE = 2'd2
  } dmr_state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ALIGN = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_RW    = 2'd3
  } dmr_err_e;

  typedef struct packed {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dmr_req_t;

endpackage

// File: rtl/dmem_responder_ram.sv
// Single-port synchronous word RAM; read data is registered and only
// refreshed by a read, so it holds the last read value across writes.
module dmem_ram #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata_q   <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM behind a fixed wait-state FSM that stalls
// the MEM stage, commits on the edge into DONE and flags bad accesses.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = DMR_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        mem_err
);

  dmr_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  dmr_req_t    req_q, req_d, eff;
  dmr_err_e    cause_q, cause_d, eff_cause;
  logic        zero_q, zero_d;
  logic        req, commit, stall_c, addr_ok;
  logic [31:0] ram_rdata;

  assign req = mem_ren | mem_wen;

  // With one wait state the commit happens straight out of IDLE, so the
  // live request is used; otherwise the latched copy is.
  always_comb begin
    eff = req_q;
    if (state_q == DMR_IDLE)
      eff = '{ren: mem_ren, wen: mem_wen, addr: mem_addr, wdata: mem_dout};
  end

  always_comb begin
    addr_ok   = (eff.addr[1:0] == 2'b00) && (eff.addr[31:ADDR_WIDTH+2] == '0);
    eff_cause = ERR_NONE;
    if (eff.addr[1:0] != 2'b00)                 eff_cause = ERR_ALIGN;
    else if (eff.addr[31:ADDR_WIDTH+2] != '0)   eff_cause = ERR_RANGE;
    else if (eff.ren && eff.wen)                eff_cause = ERR_RW;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    commit  = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      DMR_IDLE: begin
        stall_c = req;
        if (req) begin
          req_d = '{ren: mem_ren, wen: mem_wen, addr: mem_addr, wdata: mem_dout};
          cnt_d = 4'(WAIT_CYCLES - 1);
          if (WAIT_CYCLES == 1) begin
            state_d = DMR_DONE;
            commit  = 1'b1;
          end else begin
            state_d = DMR_BUSY;
          end
        end
      end
      DMR_BUSY: begin
        stall_c = 1'b1;
        if (!req) begin
          state_d = DMR_IDLE;  // flush: drop the access uncommitted
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d = DMR_DONE;
            commit  = 1'b1;
          end
        end
      end
      DMR_DONE: state_d = DMR_IDLE;
      default:  state_d = DMR_IDLE;
    endcase
  end

  // Erroring reads return zero; writes (legal or not) leave mem_din alone.
  always_comb begin
    zero_d = zero_q;
    if (commit && eff.ren && !eff.wen) zero_d = !addr_ok;
    cause_d = commit ? eff_cause : ERR_NONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DMR_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      cause_q <= ERR_NONE;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      cause_q <= cause_d;
      zero_q  <= zero_d;
    end
  end

  dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .en    (commit && addr_ok),
    .we    (eff.wen),
    .addr  (eff.addr[ADDR_WIDTH+1:2]),
    .wdata (eff.wdata),
    .rdata (ram_rdata)
  );

  assign mem_din   = zero_q ? 32'd0 : ram_rdata;
  assign mem_err   = (cause_q != ERR_NONE);
  assign mem_stall = rst_n & stall_c;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (WAIT 2, 1, 3) share
// clock and reset; a reference model pushes expected results per access.
module tb_dmem_responder;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [2:0]        ren, wen, stall, err;
  logic [2:0][31:0]  addr, dout, din;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          stall;
    logic [31:0] din;
    logic        err;
  } exp_t;

  exp_t              sbq[$];
  logic [31:0]       mdl_mem[int];
  logic [31:0]       mdl_din[3];
  int                waits[3] = '{2, 1, 3};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(W)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_ren   (ren[g]),
      .mem_wen   (wen[g]),
      .mem_addr  (addr[g]),
      .mem_dout  (dout[g]),
      .mem_din   (din[g]),
      .mem_stall (stall[g]),
      .mem_err   (err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: RAM of 2**10 words, word index = addr[11:2].
  task automatic push_exp(input int i, input bit r, input bit w,
                          input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    bit   ok = (a[1:0] == 2'b00) && (a[31:12] == 20'd0);
    int   key = i * 4096 + int'(a[11:2]);
    e.stall = waits[i];
    if (w) begin
      if (ok) mdl_mem[key] = d;
      e.din = mdl_din[i];
      e.err = !ok || r;
    end else begin
      e.din = ok ? mdl_mem[key] : 32'd0;
      e.err = !ok;
      mdl_din[i] = e.din;
    end
    sbq.push_back(e);
  endtask

  task automatic access(input int i, input bit r, input bit w,
                        input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    int   n = 0;
    push_exp(i, r, w, a, d);
    @(negedge clk);
    ren[i] = r; wen[i] = w; addr[i] = a; dout[i] = d;
    #1;
    chk("err_idle", 32'(err[i]), 32'd0);
    while (stall[i] && n < 50) begin
      n++;
      @(negedge clk); #1;
    end
    e = sbq.pop_front();
    chk("stall_cycles", n, e.stall);
    chk("din", din[i], e.din);
    chk("err_done", 32'(err[i]), 32'(e.err));
    ren[i] = 1'b0; wen[i] = 1'b0;
  endtask

  initial begin
    ren = '0; wen = '0; addr = '0; dout = '0;
    for (int k = 0; k < 3; k++) mdl_din[k] = 32'd0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_stall", 32'(stall[k]), 32'd0);
      chk("rst_din", din[k], 32'd0);
      chk("rst_err", 32'(err[k]), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // WAIT=2: write/read, misaligned write, out-of-range read, rd+wr
    access(0, 0, 1, 32'h40, 32'hDEADBEEF);
    access(0, 1, 0, 32'h40, 32'h0);
    access(0, 0, 1, 32'h42, 32'h12345678);
    access(0, 1, 0, 32'h40, 32'h0);
    access(0, 1, 0, 32'h1000, 32'h0);
    access(0, 1, 1, 32'h44, 32'h11112222);
    access(0, 1, 0, 32'h44, 32'h0);

    // WAIT=1: back-to-back accesses
    access(1, 0, 1, 32'h0, 32'h0A0A0A0A);
    access(1, 0, 1, 32'h4, 32'h0B0B0B0B);
    access(1, 1, 0, 32'h0, 32'h0);
    access(1, 1, 0, 32'h4, 32'h0);
    access(1, 1, 0, 32'h1000, 32'h0);

    // WAIT=3: flush abort in the second BUSY cycle
    access(2, 0, 1, 32'h80, 32'h5A5A0001);
    access(2, 1, 0, 32'h80, 32'h0);
    @(negedge clk);
    wen[2] = 1'b1; addr[2] = 32'h80; dout[2] = 32'hAAAA5555;
    @(negedge clk);
    @(negedge clk);
    wen[2] = 1'b0; #1;
    chk("abort_busy_stall", 32'(stall[2]), 32'd1);
    @(negedge clk); #1;
    chk("abort_idle_stall", 32'(stall[2]), 32'd0);
    chk("abort_err", 32'(err[2]), 32'd0);
    chk("abort_din", din[2], mdl_din[2]);
    access(2, 1, 0, 32'h80, 32'h0);

    // Reset in BUSY of a write: outputs clear at once, write is lost
    @(negedge clk);
    wen[2] = 1'b1; addr[2] = 32'h80; dout[2] = 32'hCAFEF00D;
    @(negedge clk); #1;
    chk("pre_rst_stall", 32'(stall[2]), 32'd1);
    rst_n = 1'b0; #1;
    chk("arst_stall", 32'(stall[2]), 32'd0);
    chk("arst_din", din[2], 32'd0);
    chk("arst_err", 32'(err[2]), 32'd0);
    for (int k = 0; k < 3; k++) mdl_din[k] = 32'd0;
    @(negedge clk);
    wen[2] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    access(2, 1, 0, 32'h80, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
